// File: rtl/dp_exec_stage.sv
// Execute stage: ARM condition check, operand-2 shifter, single-cycle ALU and
// a 32-iteration shift-add multiplier / restoring divider that stalls the pipe.
module dp_exec_stage (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ExecE,
    input  logic        RegWE,
    input  logic        ALUSrcE,
    input  logic        NoWriteE,
    input  logic        PCSE,
    input  logic [3:0]  CondE,
    input  logic [3:0]  FlagWE,
    input  logic [2:0]  WIndexE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic [31:0] ImmE,
    input  logic [1:0]  ShE,
    input  logic [4:0]  Shamt5E,
    input  logic [4:0]  OpE,
    output logic [31:0] ALUResultE,
    output logic        RegWriteCE,
    output logic [2:0]  WIndexOutE,
    output logic        PCSrcE,
    output logic        StallE,
    output logic [3:0]  FlagsE
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  nzcv;
    logic [4:0]  count;
    logic [31:0] acc;
    logic [31:0] work_a;
    logic [31:0] work_b;
    logic        is_div;

    logic        flag_n, flag_z, flag_c, flag_v;
    logic        cond_true, cond_ex;

    assign flag_n = nzcv[3];
    assign flag_z = nzcv[2];
    assign flag_c = nzcv[1];
    assign flag_v = nzcv[0];

    always_comb begin
        cond_true = 1'b0;
        case (CondE)
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = ~flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = ~flag_c;
            4'b0100: cond_true = flag_n;
            4'b0101: cond_true = ~flag_n;
            4'b0110: cond_true = flag_v;
            4'b0111: cond_true = ~flag_v;
            4'b1000: cond_true = flag_c & ~flag_z;
            4'b1001: cond_true = ~flag_c | flag_z;
            4'b1010: cond_true = (flag_n == flag_v);
            4'b1011: cond_true = (flag_n != flag_v);
            4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_true = flag_z | (flag_n != flag_v);
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign cond_ex = ExecE & cond_true;

    // Shifts widened by one bit so the last bit shifted out lands in the spare bit.
    logic [32:0] lsl_ext, lsr_ext, asr_ext;
    logic [31:0] ror_res;
    logic [31:0] src2;
    logic        sh_carry;

    assign lsl_ext = {1'b0, SrcBE} << Shamt5E;
    assign lsr_ext = {SrcBE, 1'b0} >> Shamt5E;
    assign asr_ext = $signed({SrcBE, 1'b0}) >>> Shamt5E;
    assign ror_res = (SrcBE >> Shamt5E) | (SrcBE << (6'd32 - {1'b0, Shamt5E}));

    always_comb begin
        src2     = SrcBE;
        sh_carry = flag_c;
        if (ALUSrcE) begin
            src2 = ImmE;
        end else if (Shamt5E != 5'd0) begin
            case (ShE)
                2'b00: begin src2 = lsl_ext[31:0]; sh_carry = lsl_ext[32]; end
                2'b01: begin src2 = lsr_ext[32:1]; sh_carry = lsr_ext[0];  end
                2'b10: begin src2 = asr_ext[32:1]; sh_carry = asr_ext[0];  end
                default: begin src2 = ror_res;     sh_carry = ror_res[31]; end
            endcase
        end
    end

    logic [31:0] alu_x, alu_y, alu_res;
    logic        alu_cin, arith;
    logic [32:0] sum;
    logic        sum_v;
    logic [3:0]  alu_flags;

    always_comb begin
        alu_x   = SrcAE;
        alu_y   = src2;
        alu_cin = 1'b0;
        arith   = 1'b0;
        case (OpE)
            5'd2, 5'd10: begin alu_y = ~src2; alu_cin = 1'b1; arith = 1'b1; end
            5'd3: begin alu_x = src2; alu_y = ~SrcAE; alu_cin = 1'b1; arith = 1'b1; end
            5'd4, 5'd11: arith = 1'b1;
            5'd5: begin alu_cin = flag_c; arith = 1'b1; end
            5'd6: begin alu_y = ~src2; alu_cin = flag_c; arith = 1'b1; end
            5'd7: begin alu_x = src2; alu_y = ~SrcAE; alu_cin = flag_c; arith = 1'b1; end
            default: ;
        endcase
    end

    assign sum   = {1'b0, alu_x} + {1'b0, alu_y} + {32'd0, alu_cin};
    assign sum_v = (alu_x[31] == alu_y[31]) & (sum[31] != alu_x[31]);

    always_comb begin
        alu_res = '0;
        case (OpE)
            5'd0, 5'd8:  alu_res = SrcAE & src2;
            5'd1, 5'd9:  alu_res = SrcAE ^ src2;
            5'd2, 5'd3, 5'd4, 5'd5,
            5'd6, 5'd7, 5'd10, 5'd11: alu_res = sum[31:0];
            5'd12:       alu_res = SrcAE | src2;
            5'd13:       alu_res = src2;
            5'd14:       alu_res = SrcAE & ~src2;
            5'd15:       alu_res = ~src2;
            default:     alu_res = '0;
        endcase
        if (arith)
            alu_flags = {alu_res[31], (alu_res == 32'd0), sum[32], sum_v};
        else
            alu_flags = {alu_res[31], (alu_res == 32'd0), sh_carry, flag_v};
    end

    // Restoring divide step: work_a holds dividend bits shifting out / quotient bits shifting in.
    logic [32:0] rem_sh;
    logic        div_fits;
    logic [31:0] rem_next;
    logic [31:0] mc_res;

    assign rem_sh   = {acc, work_a[31]};
    assign div_fits = (rem_sh >= {1'b0, work_b});
    assign rem_next = div_fits ? (rem_sh[31:0] - work_b) : rem_sh[31:0];
    assign mc_res   = is_div ? work_a : acc;

    logic is_mc_op, op_valid, stall, effect_ok, commit;
    logic [3:0] flags_new, flag_we;

    assign is_mc_op = (OpE == 5'd16) | (OpE == 5'd17);
    assign op_valid = (OpE < 5'd18);

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        effect_ok  = 1'b0;
        ALUResultE = '0;
        flags_new  = alu_flags;
        case (state)
            IDLE: begin
                if (is_mc_op & cond_ex) begin
                    state_next = BUSY;
                    stall      = 1'b1;
                end
                effect_ok  = op_valid & ~is_mc_op;
                ALUResultE = is_mc_op ? '0 : alu_res;
            end
            BUSY: begin
                stall = 1'b1;
                if (count == 5'd0)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                effect_ok  = 1'b1;
                ALUResultE = mc_res;
                flags_new  = {mc_res[31], (mc_res == 32'd0), flag_c, flag_v};
            end
            default: state_next = IDLE;
        endcase
    end

    assign StallE     = stall & ~Reset;
    assign commit     = cond_ex & ~stall & effect_ok & ~Reset;
    assign RegWriteCE = RegWE & ~NoWriteE & commit;
    assign PCSrcE     = PCSE & commit;
    assign flag_we    = FlagWE & {4{commit}};
    assign WIndexOutE = WIndexE;
    assign FlagsE     = nzcv;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            nzcv <= '0;
        else
            nzcv <= (nzcv & ~flag_we) | (flags_new & flag_we);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            work_a <= '0;
            work_b <= '0;
            is_div <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (state_next == BUSY) begin
                        count  <= 5'd31;
                        is_div <= OpE[0];
                        work_a <= SrcAE;
                        work_b <= src2;
                        acc    <= '0;
                    end
                end
                BUSY: begin
                    if (count != 5'd0)
                        count <= count - 5'd1;
                    if (is_div) begin
                        acc    <= rem_next;
                        work_a <= {work_a[30:0], div_fits};
                    end else begin
                        if (work_a[0])
                            acc <= acc + work_b;
                        work_a <= work_a >> 1;
                        work_b <= work_b << 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
